// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap control, tick gating and display select for a two-digit BCD stopwatch
module stopwatch_ctrl #(
  parameter bit         STOP_AT_LIMIT = 1'b0,
  parameter logic [3:0] LIMIT_TENS    = 4'd9,
  parameter logic [3:0] LIMIT_UNITS   = 4'd9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_i,
  input  logic       start_stop_i,
  input  logic       lap_reset_i,
  input  logic [3:0] cnt_tens_i,
  input  logic [3:0] cnt_units_i,
  output logic       tick_o,
  output logic       clr_o,
  output logic [3:0] disp_tens_o,
  output logic [3:0] disp_units_o,
  output logic [1:0] state_o,
  output logic       running_o,
  output logic       done_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, LAP = 2'd3} state_t;
  state_t     state, state_next;
  logic [3:0] lap_tens, lap_units;
  logic       lap_cap, clr_next, limit_hit, limit_stop;
  assign running_o    = state == RUN || state == LAP;
  assign limit_hit    = STOP_AT_LIMIT && cnt_tens_i == LIMIT_TENS && cnt_units_i == LIMIT_UNITS;
  assign limit_stop   = tick_i && running_o && limit_hit;
  assign tick_o       = tick_i && running_o && !limit_hit;
  assign disp_tens_o  = state == LAP ? lap_tens : cnt_tens_i;
  assign disp_units_o = state == LAP ? lap_units : cnt_units_i;
  assign state_o      = state;
  // start_stop beats lap_reset; a limit stop overrides whatever the buttons asked for
  always_comb begin
    state_next = state;
    lap_cap    = 1'b0;
    clr_next   = 1'b0;
    if (start_stop_i)
      state_next = state == IDLE ? RUN : state == PAUSE ? (done_o ? PAUSE : RUN) : PAUSE;
    else if (lap_reset_i && !limit_stop) begin
      lap_cap    = state == RUN;
      clr_next   = state == PAUSE;
      state_next = state == RUN ? LAP : state == LAP ? RUN : IDLE;
    end
    if (limit_stop)
      state_next = PAUSE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= IDLE;
      lap_tens  <= 4'd0;
      lap_units <= 4'd0;
      clr_o     <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      state  <= state_next;
      clr_o  <= clr_next;
      done_o <= limit_stop || (done_o && !clr_next);
      if (clr_next) begin
        lap_tens  <= 4'd0;
        lap_units <= 4'd0;
      end else if (lap_cap) begin
        lap_tens  <= cnt_tens_i;
        lap_units <= cnt_units_i;
      end
    end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: drives a free-running and a limit-0/5 instance, each with its own BCD counter
module tb_stopwatch_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       ss[2], lr[2], tk[2];
  logic       tick_o[2], clr_o[2], run_o[2], done_o[2];
  logic [3:0] ct[2], cu[2], dt[2], du[2];
  logic [1:0] st[2];
  int         checks = 0, passes = 0, ntick[2];
  int         ms[2], lt[2], lu[2], mclr[2], md[2];
  const int   on_start[4] = '{1, 2, 1, 2};
  const int   on_lap[4]   = '{0, 3, 0, 1};

  always #5 clk = ~clk;

  stopwatch_ctrl u_free (
    .clk(clk), .reset_n(reset_n), .tick_i(tk[0]), .start_stop_i(ss[0]), .lap_reset_i(lr[0]),
    .cnt_tens_i(ct[0]), .cnt_units_i(cu[0]), .tick_o(tick_o[0]), .clr_o(clr_o[0]),
    .disp_tens_o(dt[0]), .disp_units_o(du[0]), .state_o(st[0]), .running_o(run_o[0]), .done_o(done_o[0]));

  stopwatch_ctrl #(.STOP_AT_LIMIT(1'b1), .LIMIT_TENS(4'd0), .LIMIT_UNITS(4'd5)) u_lim (
    .clk(clk), .reset_n(reset_n), .tick_i(tk[1]), .start_stop_i(ss[1]), .lap_reset_i(lr[1]),
    .cnt_tens_i(ct[1]), .cnt_units_i(cu[1]), .tick_o(tick_o[1]), .clr_o(clr_o[1]),
    .disp_tens_o(dt[1]), .disp_units_o(du[1]), .state_o(st[1]), .running_o(run_o[1]), .done_o(done_o[1]));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
  endtask

  // BCD seconds counters driven by the DUT outputs
  for (genvar g = 0; g < 2; g++) begin : g_cnt
    always @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        ct[g] <= 4'd0;
        cu[g] <= 4'd0;
      end else if (clr_o[g]) begin
        ct[g] <= 4'd0;
        cu[g] <= 4'd0;
      end else if (tick_o[g]) begin
        cu[g] <= cu[g] == 4'd9 ? 4'd0 : cu[g] + 4'd1;
        if (cu[g] == 4'd9) ct[g] <= ct[g] == 4'd9 ? 4'd0 : ct[g] + 4'd1;
      end
    always @(posedge clk) if (tick_o[g]) ntick[g]++;
  end

  function automatic bit hit(int k);
    return k == 1 && ct[k] == 4'd0 && cu[k] == 4'd5;
  endfunction

  function automatic bit live(int k);
    return ms[k] == 1 || ms[k] == 3;
  endfunction

  always @(posedge clk or negedge reset_n)
    for (int k = 0; k < 2; k++)
      if (!reset_n) begin
        ms[k] = 0; lt[k] = 0; lu[k] = 0; mclr[k] = 0; md[k] = 0;
      end else begin
        automatic int  nxt  = ms[k];
        automatic bit  stop = live(k) && hit(k) && tk[k];
        mclr[k] = 0;
        if (ss[k]) begin
          if (!(ms[k] == 2 && md[k] != 0)) nxt = on_start[ms[k]];
        end else if (lr[k] && !stop) begin
          if (ms[k] == 1) begin lt[k] = ct[k]; lu[k] = cu[k]; end
          if (ms[k] == 2) begin mclr[k] = 1; md[k] = 0; lt[k] = 0; lu[k] = 0; end
          nxt = on_lap[ms[k]];
        end
        if (stop) begin nxt = 2; md[k] = 1; end
        ms[k] = nxt;
      end

  always @(negedge clk)
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("tick_o[%0d]", k), tick_o[k], tk[k] && live(k) && !hit(k));
      chk($sformatf("clr_o[%0d]", k), clr_o[k], mclr[k]);
      chk($sformatf("state[%0d]", k), st[k], ms[k]);
      chk($sformatf("running[%0d]", k), run_o[k], live(k));
      chk($sformatf("done[%0d]", k), done_o[k], md[k]);
      chk($sformatf("disp[%0d]", k), {dt[k], du[k]}, ms[k] == 3 ? {lt[k][3:0], lu[k][3:0]} : {ct[k], cu[k]});
    end

  task automatic step(int k, logic s, logic l, logic t);
    ss[k] = s; lr[k] = l; tk[k] = t;
    @(posedge clk); #1;
    ss[k] = 1'b0; lr[k] = 1'b0; tk[k] = 1'b0;
  endtask

  task automatic ticks(int k, int n);
    for (int i = 0; i < n; i++) step(k, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin ss[k] = 0; lr[k] = 0; tk[k] = 0; ntick[k] = 0; end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    chk("rst_state", st[0], 2'd0);
    chk("rst_done", done_o[1], 1'b0);
    ticks(0, 3);
    chk("idle_ticks", ntick[0], 0);
    chk("idle_disp", {dt[0], du[0]}, 8'h00);
    step(0, 1, 0, 0);
    chk("run_state", st[0], 2'd1);
    chk("run_running", run_o[0], 1'b1);
    ticks(0, 12);
    chk("run12_ticks", ntick[0], 12);
    chk("run12_disp", {dt[0], du[0]}, 8'h12);
    step(0, 0, 1, 0);
    chk("lap_state", st[0], 2'd3);
    ticks(0, 5);
    chk("lap_frozen", {dt[0], du[0]}, 8'h12);
    chk("lap_live", {ct[0], cu[0]}, 8'h17);
    step(0, 0, 1, 0);
    chk("unlap_state", st[0], 2'd1);
    chk("unlap_disp", {dt[0], du[0]}, 8'h17);
    step(0, 1, 0, 0);
    ticks(0, 4);
    chk("pause_ticks", ntick[0], 17);
    chk("pause_state", st[0], 2'd2);
    step(0, 0, 1, 0);
    chk("clr_high", clr_o[0], 1'b1);
    chk("clr_state", st[0], 2'd0);
    step(0, 0, 0, 0);
    chk("clr_low", clr_o[0], 1'b0);
    chk("clr_disp", {dt[0], du[0]}, 8'h00);
    step(0, 1, 0, 0);
    ticks(0, 99);
    chk("disp99", {dt[0], du[0]}, 8'h99);
    ticks(0, 1);
    chk("wrap00", {dt[0], du[0]}, 8'h00);
    ticks(0, 1);
    chk("wrap01", {dt[0], du[0]}, 8'h01);
    step(0, 1, 1, 0);
    chk("both_state", st[0], 2'd2);
    chk("both_disp", {dt[0], du[0]}, 8'h01);
    step(0, 1, 0, 0);
    ticks(0, 4);
    step(0, 0, 1, 0);
    ticks(0, 2);
    chk("lap05", {dt[0], du[0]}, 8'h05);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("async_state", st[0], 2'd0);
    chk("async_running", run_o[0], 1'b0);
    chk("async_disp", {dt[0], du[0]}, 8'h00);
    @(posedge clk); #1 reset_n = 1'b1;
    step(1, 1, 0, 0);
    ticks(1, 8);
    chk("lim_disp", {dt[1], du[1]}, 8'h05);
    chk("lim_state", st[1], 2'd2);
    chk("lim_done", done_o[1], 1'b1);
    chk("lim_ticks", ntick[1], 5);
    step(1, 1, 0, 0);
    chk("lim_ignore", st[1], 2'd2);
    step(1, 0, 1, 0);
    chk("lim_idle", st[1], 2'd0);
    chk("lim_undone", done_o[1], 1'b0);
    chk("lim_clr", clr_o[1], 1'b1);
    step(1, 0, 0, 0);
    chk("lim_clr_low", clr_o[1], 1'b0);
    chk("lim_disp0", {dt[1], du[1]}, 8'h00);
    step(1, 1, 0, 0);
    ticks(1, 3);
    chk("lim_restart", {dt[1], du[1]}, 8'h03);
    @(negedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
